// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// Optional zero-latency bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
package fetch_queue_pkg;

    localparam int PC_WIDTH_DEF   = 64;
    localparam int INST_WIDTH_DEF = 32;

    // addi x0, x0, 0: decode sees this whenever no real instruction is offered.
    localparam logic [INST_WIDTH_DEF-1:0] FQ_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [PC_WIDTH_DEF-1:0]   pc;
        logic [INST_WIDTH_DEF-1:0] inst;
    } fq_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } fq_occ_e;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: one write port, one combinational read port.
// Contents are deliberately not reset; validity is tracked by the queue's count.
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic [WIDTH-1:0]         wrData,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output logic [WIDTH-1:0]         rdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode with valid/ready on both sides and
// single-cycle flush. Define FETCH_QUEUE_BYPASS_EN for an empty-queue bypass path.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int PC_WIDTH        = PC_WIDTH_DEF,
    parameter int INST_WIDTH      = INST_WIDTH_DEF,
    parameter int ALMOST_FULL_LVL = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [PC_WIDTH-1:0]          enq_pc,
    input  logic [INST_WIDTH-1:0]        enq_inst,
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [PC_WIDTH-1:0]          deq_pc,
    output logic [INST_WIDTH-1:0]        deq_inst,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = PC_WIDTH + INST_WIDTH;

    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic [CNT_W-1:0]      countNext;
    logic [ENTRY_W-1:0]    headEntry;
    logic [PC_WIDTH-1:0]   headPc;
    logic [INST_WIDTH-1:0] headInst;
    fq_occ_e               occ;
    logic                  notEmpty;
    logic                  notFull;
    logic                  bypassActive;
    logic                  bypassTaken;
    logic                  deqFire;
    logic                  enqFire;
    logic                  memWrite;
    logic                  memPop;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) uMem (
        .clk    (clk),
        .wrEn   (memWrite),
        .wrAddr (wrPtr),
        .wrData ({enq_pc, enq_inst}),
        .rdAddr (rdPtr),
        .rdData (headEntry)
    );

    assign headPc   = headEntry[ENTRY_W-1 -: PC_WIDTH];
    assign headInst = headEntry[INST_WIDTH-1:0];

    always_comb begin
        occ = OCC_PARTIAL;
        if (count == '0) begin
            occ = OCC_EMPTY;
        end else if (count == CNT_W'(DEPTH)) begin
            occ = OCC_FULL;
        end
    end

    assign notEmpty = (occ != OCC_EMPTY);
    assign notFull  = (occ != OCC_FULL);

`ifdef FETCH_QUEUE_BYPASS_EN
    // An empty queue forwards the fetch entry straight to decode; it is only
    // stored if decode does not take it this cycle.
    assign bypassActive = !notEmpty && enq_valid && !flush;
`else
    assign bypassActive = 1'b0;
`endif

    assign bypassTaken = bypassActive && deq_ready;
    assign deq_valid   = (notEmpty && !flush) || bypassActive;
    assign deqFire     = deq_valid && deq_ready;
    // A full queue still accepts when the head leaves in the same cycle.
    assign enq_ready   = !flush && (notFull || deqFire);
    assign enqFire     = enq_valid && enq_ready;
    assign memWrite    = enqFire && !bypassTaken;
    assign memPop      = deqFire && !bypassTaken;

    always_comb begin
        deq_pc   = '0;
        deq_inst = INST_WIDTH'(FQ_NOP);
        if (bypassActive) begin
            deq_pc   = enq_pc;
            deq_inst = enq_inst;
        end else if (deq_valid) begin
            deq_pc   = headPc;
            deq_inst = headInst;
        end
    end

    always_comb begin
        countNext = count;
        case ({memWrite, memPop})
            2'b10:   countNext = count + CNT_W'(1);
            2'b01:   countNext = count - CNT_W'(1);
            default: countNext = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (memWrite) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (memPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= countNext;
        end
    end

    assign almost_full = (count >= CNT_W'(ALMOST_FULL_LVL));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4); follows the
// FETCH_QUEUE_BYPASS_EN setting of the build for the bypass-dependent checks.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        enq_valid;
    logic        enq_ready;
    logic [63:0] enq_pc;
    logic [31:0] enq_inst;
    logic        deq_valid;
    logic        deq_ready;
    logic [63:0] deq_pc;
    logic [31:0] deq_inst;
    logic [2:0]  count;
    logic        almost_full;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .enq_valid   (enq_valid),
        .enq_ready   (enq_ready),
        .enq_pc      (enq_pc),
        .enq_inst    (enq_inst),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_pc      (deq_pc),
        .deq_inst    (deq_inst),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge, then let outputs settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] inst);
        enq_valid = 1'b1;
        enq_pc    = pc;
        enq_inst  = inst;
    endtask

    initial begin
        fq_entry_t e;
        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        enq_pc = '0; enq_inst = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_deq_valid", deq_valid, 0);
        chk("rst_deq_inst", deq_inst, 32'h13);
        chk("rst_deq_pc", deq_pc, 0);
        chk("rst_enq_ready", enq_ready, 1);
        chk("rst_almost_full", almost_full, 0);

        // Fill with decode stalled.
        for (int i = 0; i < 4; i++) begin
            push(64'h8000_0000 + 64'(4 * i), 32'h11 + 32'(i));
            tick();
            if (i == 1) chk("fill2_almost_full", almost_full, 0);
            if (i == 2) chk("fill3_almost_full", almost_full, 1);
        end
        enq_valid = 1'b0;
        #1;
        chk("full_count", count, 4);
        chk("full_enq_ready", enq_ready, 0);
        chk("full_almost_full", almost_full, 1);
        chk("full_head_pc", deq_pc, 64'h8000_0000);
        chk("full_head_inst", deq_inst, 32'h11);

        // Push into a full queue while the head pops.
        push(64'h8000_0010, 32'h15);
        deq_ready = 1'b1;
        #1;
        chk("full_pp_enq_ready", enq_ready, 1);
        tick();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        #1;
        chk("full_pp_count", count, 4);

        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_valid", deq_valid, 1);
            chk("drain_pc", deq_pc, 64'h8000_0004 + 64'(4 * i));
            chk("drain_inst", deq_inst, 32'h12 + 32'(i));
            tick();
        end
        deq_ready = 1'b0;
        #1;
        chk("drained_valid", deq_valid, 0);
        chk("drained_count", count, 0);
        chk("drained_inst", deq_inst, 32'h13);

        // Flush with three entries plus a concurrent enqueue.
        for (int i = 0; i < 3; i++) begin
            push(64'h8000_00A0 + 64'(4 * i), 32'h41 + 32'(i));
            tick();
        end
        enq_valid = 1'b0;
        #1;
        chk("pre_flush_count", count, 3);
        flush = 1'b1;
        push(64'h8000_0300, 32'h51);
        #1;
        chk("flush_deq_valid", deq_valid, 0);
        chk("flush_deq_inst", deq_inst, 32'h13);
        chk("flush_enq_ready", enq_ready, 0);
        tick();
        flush = 1'b0;
        enq_valid = 1'b0;
        #1;
        chk("post_flush_count", count, 0);
        chk("post_flush_valid", deq_valid, 0);
        push(64'h8000_0100, 32'h21);
        tick();
        enq_valid = 1'b0;
        #1;
        chk("post_flush_first_pc", deq_pc, 64'h8000_0100);
        chk("post_flush_count1", count, 1);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        #1;
        chk("post_flush_empty", count, 0);

        // Continuous push/pop across pointer wrap.
        deq_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            e.pc   = 64'h8000_1000 + 64'(4 * i);
            e.inst = 32'h100 + 32'(i);
            push(e.pc, e.inst);
            #1;
`ifdef FETCH_QUEUE_BYPASS_EN
            chk("wrap_valid", deq_valid, 1);
            chk("wrap_pc", deq_pc, e.pc);
            chk("wrap_inst", deq_inst, e.inst);
`else
            chk("wrap_valid", deq_valid, (i == 0) ? 1'b0 : 1'b1);
            if (i > 0) begin
                chk("wrap_pc", deq_pc, e.pc - 64'd4);
                chk("wrap_inst", deq_inst, e.inst - 32'd1);
            end
`endif
            tick();
            chk("wrap_count_le1", (count <= 3'd1), 1);
        end
        enq_valid = 1'b0;
        tick();
        deq_ready = 1'b0;
        #1;
        chk("wrap_end_count", count, 0);

        // Empty queue, decode ready: bypass or one-cycle latency.
        push(64'h8000_0200, 32'h31);
        deq_ready = 1'b1;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("byp_valid", deq_valid, 1);
        chk("byp_pc", deq_pc, 64'h8000_0200);
        tick();
        enq_valid = 1'b0;
        #1;
        chk("byp_count", count, 0);
        chk("byp_after_valid", deq_valid, 0);
`else
        chk("nobyp_valid", deq_valid, 0);
        tick();
        enq_valid = 1'b0;
        #1;
        chk("nobyp_late_valid", deq_valid, 1);
        chk("nobyp_late_pc", deq_pc, 64'h8000_0200);
        chk("nobyp_count", count, 1);
        tick();
        #1;
        chk("nobyp_drained", count, 0);
`endif
        deq_ready = 1'b0;

        // Reset mid-operation dominates handshakes.
        push(64'h8000_0400, 32'h61);
        tick();
        push(64'h8000_0404, 32'h62);
        tick();
        chk("pre_rst_count", count, 2);
        rst = 1'b1;
        deq_ready = 1'b1;
        tick();
        rst = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", deq_valid, 0);
        chk("mid_rst_inst", deq_inst, 32'h13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
